// File: rtl/stopwatch_core_n.sv
// N-digit BCD stopwatch/timer: prescaler, run FSM, up/down BCD chain, lap register (STOPWATCH_LAP_EN).
// Digits change on the prescaler step edge with no added latency; pulse inputs are never backpressured.
module stopwatch_core_n #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_p,
  input  logic                  stop_p,
  input  logic                  clear_p,
  input  logic                  lap_p,
  input  logic                  load_p,
  input  logic                  mode_down,
  input  logic [4*DIGITS-1:0]   preset,
  output logic [4*DIGITS-1:0]   digits,
  output logic [4*DIGITS-1:0]   lap_digits,
  output logic                  lap_valid,
  output logic                  running,
  output logic                  done,
  output logic                  done_p
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [W-1:0]  ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t         state, state_nx;
  logic [PW-1:0]  presc, presc_nx;
  logic [W-1:0]   digits_nx;
  logic           dir, dir_nx;
  logic           step;
  logic           terminal;
  logic [W-1:0]   stepped;

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Saturating at both ends so a run can never wrap past the terminal value.
  always_comb begin
    step = (state == RUN) && (presc == PRESC_MAX);
    if (dir) begin
      stepped  = (digits == '0) ? '0 : bcd_dec(digits);
      terminal = (stepped == '0);
    end else begin
      stepped  = (digits == ALL_NINES) ? ALL_NINES : bcd_inc(digits);
      terminal = (stepped == ALL_NINES);
    end
  end

  always_comb begin
    state_nx  = state;
    presc_nx  = presc;
    digits_nx = digits;
    dir_nx    = dir;
    if (clear_p) begin
      state_nx  = IDLE;
      presc_nx  = '0;
      digits_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          presc_nx = '0;
          if (stop_p) begin
            state_nx = IDLE;
          end else if (start_p) begin
            dir_nx = mode_down;
            if (!(mode_down && digits == '0)) state_nx = RUN;
          end else if (load_p) begin
            digits_nx = bcd_clamp(preset);
          end
        end
        RUN: begin
          presc_nx = step ? '0 : presc + PW'(1);
          if (step) digits_nx = stepped;
          // A terminal step outranks a simultaneous stop.
          if (step && terminal) begin
            state_nx = DONE;
          end else if (stop_p) begin
            state_nx = PAUSE;
          end
        end
        PAUSE: begin
          if (!stop_p && start_p) state_nx = RUN;
        end
        DONE: begin
          presc_nx = '0;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      presc  <= '0;
      digits <= '0;
      dir    <= 1'b0;
      done_p <= 1'b0;
    end else begin
      state  <= state_nx;
      presc  <= presc_nx;
      digits <= digits_nx;
      dir    <= dir_nx;
      done_p <= (state_nx == DONE) && (state != DONE);
    end
  end

  assign running = (state == RUN);
  assign done    = (state == DONE);

`ifdef STOPWATCH_LAP_EN
  // Samples the registered count, so a lap on a step edge keeps the pre-step value.
  always_ff @(posedge clk) begin
    if (rst || clear_p) begin
      lap_digits <= '0;
      lap_valid  <= 1'b0;
    end else if (lap_p && (state == RUN || state == PAUSE)) begin
      lap_digits <= digits;
      lap_valid  <= 1'b1;
    end
  end
`else
  logic unused_lap;
  assign unused_lap = lap_p;
  assign lap_digits = '0;
  assign lap_valid  = 1'b0;
`endif

endmodule
